// File: rtl/costas_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : costas_stage_scheduler
// Brief    : Sample-tick divider and stage-strobe sequencer for the Costas loop.
//            Define COSTAS_SCHED_OVR_CNT_EN to add the ovr_count dropped-tick counter.
// Revision : 1.0
// ============================================================================
module costas_stage_scheduler #(
    parameter int DIV_W       = 6,
    parameter int DIV_DEFAULT = 15,
    parameter int LF_TIMEOUT  = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             lf_done,
    input  logic             status_clr,
    output logic             sample_tick,
    output logic             mix_en,
    output logic             lpf_en,
    output logic             pd_en,
    output logic             lf_start,
    output logic             nco_en,
    output logic             busy,
    output logic             overrun,
`ifdef COSTAS_SCHED_OVR_CNT_EN
    output logic             lf_timeout,
    output logic [7:0]       ovr_count
`else
    output logic             lf_timeout
`endif
);

    localparam int c_WCNT_W = $clog2(LF_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MIX      = 3'd1,
        S_LPF      = 3'd2,
        S_PD       = 3'd3,
        S_LF_START = 3'd4,
        S_LF_WAIT  = 3'd5,
        S_NCO      = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_period;
    logic [DIV_W-1:0]    w_ratio;
    logic                w_wrap;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_WCNT_W-1:0] w_wcnt_inc;
    logic                w_ovr_set;
    logic                w_tout_set;

    assign w_ratio    = (div_ratio < DIV_W'(2)) ? DIV_W'(2) : div_ratio;
    assign w_wrap     = (r_cnt == r_period - DIV_W'(1));
    assign w_wcnt_inc = r_wcnt + c_WCNT_W'(1);
    assign w_ovr_set  = sample_tick && (r_state != S_IDLE);

    // Period register only follows div_ratio at wrap so a period is never cut short.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_period    <= DIV_W'(DIV_DEFAULT);
            sample_tick <= 1'b0;
        end else if (!enable) begin
            r_cnt       <= '0;
            sample_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt       <= '0;
            r_period    <= w_ratio;
            sample_tick <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + DIV_W'(1);
            sample_tick <= 1'b0;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tout_set = 1'b0;
        case (r_state)
            S_IDLE:     if (sample_tick) w_next = S_MIX;
            S_MIX:      w_next = S_LPF;
            S_LPF:      w_next = S_PD;
            S_PD:       w_next = S_LF_START;
            S_LF_START: w_next = S_LF_WAIT;
            S_LF_WAIT: begin
                // A done arriving on the last permitted wait cycle still wins.
                if (lf_done) begin
                    w_next = S_NCO;
                end else if (w_wcnt_inc == c_WCNT_W'(LF_TIMEOUT)) begin
                    w_next     = S_IDLE;
                    w_tout_set = 1'b1;
                end
            end
            S_NCO:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            mix_en     <= 1'b0;
            lpf_en     <= 1'b0;
            pd_en      <= 1'b0;
            lf_start   <= 1'b0;
            nco_en     <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            lf_timeout <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wcnt     <= (r_state == S_LF_WAIT) ? w_wcnt_inc : '0;
            mix_en     <= (w_next == S_MIX);
            lpf_en     <= (w_next == S_LPF);
            pd_en      <= (w_next == S_PD);
            lf_start   <= (w_next == S_LF_START);
            nco_en     <= (w_next == S_NCO);
            busy       <= (w_next != S_IDLE);
            overrun    <= w_ovr_set  | (overrun    & ~status_clr);
            lf_timeout <= w_tout_set | (lf_timeout & ~status_clr);
        end
    end

`ifdef COSTAS_SCHED_OVR_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_count <= 8'd0;
        end else if (w_ovr_set) begin
            if (status_clr)
                ovr_count <= 8'd1;
            else if (ovr_count != 8'hFF)
                ovr_count <= ovr_count + 8'd1;
        end else if (status_clr) begin
            ovr_count <= 8'd0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_costas_stage_scheduler.sv
`default_nettype none
// Bench for costas_stage_scheduler: directed scenarios plus randomized traffic,
// compared every cycle against a time-offset model of the stage sequence.
module tb_costas_stage_scheduler;

    localparam int DIV_W       = 6;
    localparam int DIV_DEFAULT = 15;
    localparam int LF_TIMEOUT  = 8;
    localparam int LAST_WAIT   = 4 + LF_TIMEOUT;   // age of final wait cycle

    logic             clock      = 1'b0;
    logic             reset_n    = 1'b0;
    logic             enable     = 1'b0;
    logic [DIV_W-1:0] div_ratio  = 6'd15;
    logic             lf_done    = 1'b0;
    logic             status_clr = 1'b0;
    logic sample_tick, mix_en, lpf_en, pd_en, lf_start, nco_en, busy, overrun, lf_timeout;
`ifdef COSTAS_SCHED_OVR_CNT_EN
    logic [7:0] ovr_count;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int mode = 0;          // 0: done 1 cycle after lf_start, 1: never, 2: random
    int done_cd = -1;
    bit nco_seen = 1'b0;
    int n;

    costas_stage_scheduler #(
        .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT), .LF_TIMEOUT(LF_TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .div_ratio(div_ratio),
        .lf_done(lf_done), .status_clr(status_clr), .sample_tick(sample_tick),
        .mix_en(mix_en), .lpf_en(lpf_en), .pd_en(pd_en), .lf_start(lf_start),
        .nco_en(nco_en), .busy(busy), .overrun(overrun),
`ifdef COSTAS_SCHED_OVR_CNT_EN
        .lf_timeout(lf_timeout), .ovr_count(ovr_count)
`else
        .lf_timeout(lf_timeout)
`endif
    );

    always #5 clock = ~clock;

    // Model: a sequence is described by its age (cycles since the accepted
    // tick) and the age at which lf_done was accepted.
    int   m_elapsed = 0, m_period = DIV_DEFAULT, m_age = 0, m_done_age = -1, m_cnt = 0;
    bit   m_tick = 0, m_active = 0, m_ovr = 0, m_lft = 0;
    logic [8:0] exp_vec = '0;

    initial forever begin
        bit busy_now, ovr_set, tout_set;
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            m_elapsed = 0; m_period = DIV_DEFAULT; m_tick = 0;
            m_active = 0; m_age = 0; m_done_age = -1;
            m_ovr = 0; m_lft = 0; m_cnt = 0; exp_vec = '0;
        end else begin
            busy_now = m_active;
            ovr_set  = m_tick && busy_now;
            if (m_active && m_done_age < 0 && m_age >= 5 && m_age <= LAST_WAIT && lf_done)
                m_done_age = m_age;
            tout_set = m_active && m_done_age < 0 && m_age == LAST_WAIT;
            if (m_active) begin
                m_age++;
                if (m_done_age >= 0 ? (m_age > m_done_age + 1) : (m_age > LAST_WAIT))
                    m_active = 0;
            end
            if (m_tick && !busy_now) begin
                m_active = 1; m_age = 1; m_done_age = -1;
            end
            m_ovr = ovr_set  || (m_ovr && !status_clr);
            m_lft = tout_set || (m_lft && !status_clr);
            if (ovr_set) m_cnt = status_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            else if (status_clr) m_cnt = 0;
            if (enable) begin
                m_elapsed++;
                if (m_elapsed == m_period) begin
                    m_tick = 1; m_elapsed = 0;
                    m_period = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
                end else begin
                    m_tick = 0;
                end
            end else begin
                m_elapsed = 0; m_tick = 0;
            end
            exp_vec = {m_tick, m_active && m_age == 1, m_active && m_age == 2,
                       m_active && m_age == 3, m_active && m_age == 4,
                       m_active && m_done_age >= 0 && m_age == m_done_age + 1,
                       m_active, m_ovr, m_lft};
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            checks++;
            if ({sample_tick, mix_en, lpf_en, pd_en, lf_start, nco_en, busy, overrun, lf_timeout} !== exp_vec) begin
                errors++;
                $display("FAIL outputs t=%0t got %b want %b", $time,
                    {sample_tick, mix_en, lpf_en, pd_en, lf_start, nco_en, busy, overrun, lf_timeout}, exp_vec);
            end
`ifdef COSTAS_SCHED_OVR_CNT_EN
            checks++;
            if (int'(ovr_count) != m_cnt) begin
                errors++;
                $display("FAIL ovr_count t=%0t got %0d want %0d", $time, ovr_count, m_cnt);
            end
`endif
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Advances n cycles; lands 1 time unit after the edge and plays the loop filter.
    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            lf_done = 1'b0;
            if (done_cd == 0) begin
                lf_done = 1'b1; done_cd = -1;
            end else if (done_cd > 0) begin
                done_cd--;
            end
            if (lf_start) begin
                if (mode == 0) done_cd = 0;
                else if (mode == 2) done_cd = $urandom_range(0, 10);
            end
            if (mode == 2 && $urandom_range(0, 15) == 0) lf_done = 1'b1;
            if (nco_en) nco_seen = 1'b1;
        end
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!sample_tick && cnt < 100);
        if (!sample_tick) begin
            checks++; errors++;
            $display("FAIL tick_wait got no tick want tick within 100 cycles");
        end
    endtask

    initial begin
        @(posedge clock); #1;
        chk_en = 1'b1;
        step(2);
        reset_n = 1'b1; enable = 1'b1; div_ratio = 6'd15; mode = 0;
        wait_tick(n);  check("first_tick", n, 15);
        wait_tick(n);  check("period_15", n, 15);
        step(4);       check("lf_start_T4", int'(lf_start), 1);
        step(2);       check("nco_T6", int'(nco_en), 1);
        step(1);       check("idle_T7", int'({busy, overrun, lf_timeout}), 0);

        wait_tick(n);
        step(5);
        div_ratio = 6'd10;
        wait_tick(n);  check("mid_change_keeps_15", n, 10);
        wait_tick(n);  check("new_period_10", n, 10);

        div_ratio = 6'd7;
        wait_tick(n);
        step(60);      check("no_overrun_at_7", int'(overrun), 0);
        div_ratio = 6'd6;
        step(40);      check("overrun_at_6", int'(overrun), 1);
`ifdef COSTAS_SCHED_OVR_CNT_EN
        check("ovr_count_counts", int'(ovr_count > 8'd1), 1);
`endif
        enable = 1'b0;
        step(20);
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        check("clr_overrun", int'(overrun), 0);

        mode = 1; div_ratio = 6'd15; enable = 1'b1; nco_seen = 1'b0;
        wait_tick(n);  check("held_period_6", n, 6);
        step(12);      check("busy_last_wait", int'({busy, lf_timeout}), 2);
        step(1);       check("timeout_set", int'(lf_timeout), 1);
        check("timeout_idle", int'(busy), 0);
        check("no_nco", int'(nco_seen), 0);
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        check("clr_timeout", int'(lf_timeout), 0);

        wait_tick(n);
        step(7);
        #2 reset_n = 1'b0;
        #1 check("reset_async",
                 int'({sample_tick, mix_en, lpf_en, pd_en, lf_start, nco_en, busy, overrun, lf_timeout}), 0);
        @(posedge clock); #1;
        reset_n = 1'b1; div_ratio = 6'd0; mode = 0; done_cd = -1;
        wait_tick(n);  check("tick_after_reset", n, DIV_DEFAULT);
        wait_tick(n);  check("ratio0_period", n, 2);
        step(1);       check("ratio0_overrun", int'(overrun), 1);

        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            enable     = ($urandom_range(0, 19) != 0);
            status_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) div_ratio = DIV_W'($urandom_range(0, 20));
        end
        status_clr = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
